// File: rtl/retire_trace_buf_pkg.sv
// retire_trace_buf_pkg
//   Shared constants and record-layout helpers for the retire trace buffer.
//   The lock-step checker imports this package to unpack out_rec without
//   duplicating the field layout.
//
//   Record layout, MSB first:
//     {seq[SEQW], pc[32], rf_we[1], waddr[5], wdata[32], be[4], addr[AW], mdata[32]}
//   The *_lsb functions return the bit offset of each field's LSB within
//   out_rec. The offsets depend only on AW. seq takes the top SEQW bits.
package retire_trace_buf_pkg;

  // Data-memory address width of the core.
  localparam int MEM_ADDR_WIDTH = 12;

  // Packed record width. Derived from the field widths and never overridden.
  function automatic int rec_w(input int seqw, input int aw);
    return seqw + 32 + 1 + 5 + 32 + 4 + aw + 32;
  endfunction

  function automatic int rec_mdata_lsb();
    return 0;
  endfunction

  function automatic int rec_addr_lsb();
    return 32;
  endfunction

  function automatic int rec_be_lsb(input int aw);
    return 32 + aw;
  endfunction

  function automatic int rec_wdata_lsb(input int aw);
    return 36 + aw;
  endfunction

  function automatic int rec_waddr_lsb(input int aw);
    return 68 + aw;
  endfunction

  function automatic int rec_rfwe_lsb(input int aw);
    return 73 + aw;
  endfunction

  function automatic int rec_pc_lsb(input int aw);
    return 74 + aw;
  endfunction

  function automatic int rec_seq_lsb(input int aw);
    return 106 + aw;
  endfunction

endpackage

// File: rtl/retire_trace_buf_if.sv
// retire_trace_buf_if
//   Bundles the signals between the core, the trace buffer and the trace
//   consumer.
//     Core side   : retire, retire_pc, rf_we, rf_waddr, rf_wdata,
//                   mem_be, mem_addr, mem_wdata
//     Stream side : out_valid, out_ready, out_rec
//     Status      : overflow, clr_ovf, drop_cnt, level
//
//   Stream handshake: a record transfers on a rising clk edge where
//   out_valid & out_ready are both 1. The source never withdraws out_valid
//   and never changes out_rec until that transfer happens. out_valid does
//   not depend on out_ready. The core side has no ready signal, so the buffer
//   can never stall the core.
//
//   Modports:
//     master : the core and the consumer, which drive the buffer.
//     slave  : the trace buffer itself.
interface retire_trace_buf_if
  import retire_trace_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = MEM_ADDR_WIDTH,
  parameter int SEQW  = 16
) ();

  logic                          retire;
  logic [31:0]                   retire_pc;
  logic                          rf_we;
  logic [4:0]                    rf_waddr;
  logic [31:0]                   rf_wdata;
  logic [3:0]                    mem_be;
  logic [AW-1:0]                 mem_addr;
  logic [31:0]                   mem_wdata;

  logic                          out_valid;
  logic                          out_ready;
  logic [rec_w(SEQW, AW)-1:0]    out_rec;

  logic                          overflow;
  logic                          clr_ovf;
  logic [7:0]                    drop_cnt;
  logic [$clog2(DEPTH):0]        level;

  modport master (
    output retire, retire_pc, rf_we, rf_waddr, rf_wdata,
           mem_be, mem_addr, mem_wdata, out_ready, clr_ovf,
    input  out_valid, out_rec, overflow, drop_cnt, level
  );

  modport slave (
    input  retire, retire_pc, rf_we, rf_waddr, rf_wdata,
           mem_be, mem_addr, mem_wdata, out_ready, clr_ovf,
    output out_valid, out_rec, overflow, drop_cnt, level
  );

endinterface

// File: rtl/retire_trace_buf_fifo.sv
// sync_fifo_fwft
//   Generic synchronous first-word-fall-through FIFO.
//   Ports:
//     clk, rst   clock; asynchronous active-low reset (clears pointers only)
//     i_push     write i_wdata this edge (ignored when full without pop)
//     i_wdata    write data
//     i_pop      consume the head entry this edge (ignored when empty)
//     o_rdata    head entry, taken straight from storage; 0 while empty
//     o_full     DEPTH entries held
//     o_empty    no entries held
//     o_level    occupancy, 0..DEPTH
//   DEPTH must be a power of two and at least 2.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);

  // The pointers carry one extra wrap bit. Equal pointers mean empty.
  // Pointers that differ only in the wrap bit mean full.
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO is allowed when the same edge frees the head slot.
  // The write lands in the slot being vacated, and that slot becomes the tail,
  // so older entries still leave first.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset. The o_empty gate hides stale contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/retire_trace_buf.sv
// retire_trace_buf
//   Commit-trace buffer placed downstream of the pipelined core. It forms one
//   record per retired instruction (PC, register-file write, store), queues
//   the records in a FWFT FIFO and streams them out under valid/ready.
//   Ports:
//     clk    clock
//     rst    asynchronous active-low reset
//     bus    retire_trace_buf_if.slave, which carries:
//            core inputs (retire, retire_pc, rf_*, mem_*),
//            the output stream (out_valid/out_ready/out_rec), and
//            status (overflow, clr_ovf, drop_cnt, level)
//   The buffer only observes the core. A record that arrives while the FIFO
//   is full and not popping is dropped and counted. seq still advances for a
//   dropped record, so the consumer sees a gap in the numbering.
module retire_trace_buf
  import retire_trace_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = MEM_ADDR_WIDTH,
  parameter int SEQW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  retire_trace_buf_if.slave bus
);

  localparam int REC_W = rec_w(SEQW, AW);
  localparam int LW    = $clog2(DEPTH) + 1;

  logic [SEQW-1:0]  r_seq;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_rf_we;
  logic             w_store;
  logic [AW-1:0]    w_addr;
  logic [31:0]      w_mdata;
  logic [REC_W-1:0] w_rec;
  logic [REC_W-1:0] w_fifo_rdata;
  logic [LW-1:0]    w_level;

  assign w_pop  = ~w_empty & bus.out_ready;
  assign w_push = bus.retire & (~w_full | w_pop);
  assign w_drop = bus.retire & w_full & ~w_pop;

  // A write to r0 is architecturally a no-op, so its write enable is cleared.
  // The address and data are kept as presented.
  assign w_rf_we = bus.rf_we & (bus.rf_waddr != 5'd0);
  assign w_store = (bus.mem_be != 4'd0);
  assign w_addr  = w_store ? bus.mem_addr  : '0;
  assign w_mdata = w_store ? bus.mem_wdata : '0;

  assign w_rec = {r_seq, bus.retire_pc, w_rf_we, bus.rf_waddr, bus.rf_wdata,
                  bus.mem_be, w_addr, w_mdata};

  sync_fifo_fwft #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_rec),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (bus.retire) r_seq <= r_seq + SEQW'(1);
      // A drop on the same edge as clr_ovf wins, so drop_cnt restarts at 1.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (bus.clr_ovf)             r_drop_cnt <= 8'd1;
        else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end else if (bus.clr_ovf) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= 8'd0;
      end
    end
  end

  assign bus.out_valid = ~w_empty;
  assign bus.out_rec   = w_fifo_rdata;
  assign bus.overflow  = r_overflow;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.level     = w_level;

endmodule
